// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one external combinational
// FP16 multiplier. One operation is in flight at a time, with 2 cycles from accept to response.
module fp16_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 busy,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, win_id, id_q;
  logic           win_found, accept;
  logic [15:0]    op_a_q, op_b_q, data_q, op_count_q;

  // Rotating priority: the requester just after last_grant is searched first.
  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a value unassigned (no latch).
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req_valid[(int'(last_grant) + k) % NREQ]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // The grant only goes out when the winner is valid, so ready implies accept.
        if (!rst && win_found) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (win_id == IDW'(i));
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= '0;
      data_q     <= '0;
      op_count_q <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      if (accept) begin
        op_a_q     <= req_a[16*int'(win_id) +: 16];
        op_b_q     <= req_b[16*int'(win_id) +: 16];
        id_q       <= win_id;
        last_grant <= win_id;
      end
      if (state == ISSUE) data_q <= mul_result;
      if (state == RESP && rsp_ready) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);
  assign op_count  = op_count_q;

endmodule
